// File: rtl/hpgp_itl_ctrl.sv
// Sequencer for the HPGP turbo-interleaver datapath: linear fill, interleaved
// read sweep, and framed forwarding of the returned pairs.
module hpgp_itl_ctrl #(
  parameter int D_WIDTH   = 2,
  parameter int A_WIDTH   = 12,
  parameter int PB136_LEN = 544,
  parameter int PB520_LEN = 2080,
  parameter int PB136_OFS = 0,
  parameter int PB520_OFS = 544
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pb_sel,
  output logic               busy,
  input  logic [D_WIDTH-1:0] din,
  input  logic               din_vld,
  output logic               din_rdy,
  input  logic               din_last,
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_vld,
  output logic               dout_last,
  output logic               done,
  output logic               len_err,
  output logic [D_WIDTH-1:0] ram_wdata,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic               ram_wen,
  output logic [A_WIDTH-1:0] ram_pb_offset,
  output logic               ram_din_vld,
  input  logic [D_WIDTH-1:0] ram_rdata_itl,
  input  logic               ram_dout_vld
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_FLUSH} state_t;

  localparam logic [A_WIDTH-1:0] N136 = A_WIDTH'(PB136_LEN);
  localparam logic [A_WIDTH-1:0] N520 = A_WIDTH'(PB520_LEN);
  localparam logic [A_WIDTH-1:0] O136 = A_WIDTH'(PB136_OFS);
  localparam logic [A_WIDTH-1:0] O520 = A_WIDTH'(PB520_OFS);

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] n_q, n_d;
  logic [A_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [A_WIDTH-1:0] rcnt_q, rcnt_d;
  logic [A_WIDTH-1:0] ocnt_q, ocnt_d;
  logic               len_err_q, len_err_d;
  logic [D_WIDTH-1:0] dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               dout_last_q, dout_last_d;
  logic               done_q, done_d;
  logic [D_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [A_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
  logic               ram_wen_q, ram_wen_d;
  logic [A_WIDTH-1:0] ram_pb_offset_q, ram_pb_offset_d;
  logic               ram_din_vld_q, ram_din_vld_d;

  logic [A_WIDTH-1:0] n_m1;
  logic               hs;

  assign n_m1 = n_q - 1'b1;
  assign hs   = din_vld && (state_q == S_FILL);

  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    wcnt_d          = wcnt_q;
    rcnt_d          = rcnt_q;
    ocnt_d          = ocnt_q;
    len_err_d       = len_err_q;
    dout_d          = dout_q;
    dout_vld_d      = 1'b0;
    dout_last_d     = 1'b0;
    done_d          = 1'b0;
    ram_wdata_d     = ram_wdata_q;
    ram_waddr_d     = ram_waddr_q;
    ram_wen_d       = 1'b0;
    ram_pb_offset_d = ram_pb_offset_q;
    ram_din_vld_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d             = pb_sel ? N520 : N136;
          ram_pb_offset_d = pb_sel ? O520 : O136;
          wcnt_d          = '0;
          rcnt_d          = '0;
          ocnt_d          = '0;
          len_err_d       = 1'b0;
          state_d         = S_FILL;
        end
      end
      S_FILL: begin
        if (hs) begin
          ram_wen_d   = 1'b1;
          ram_waddr_d = wcnt_q;
          ram_wdata_d = din;
          wcnt_d      = wcnt_q + 1'b1;
          // din_last must coincide exactly with the Nth pair
          if (din_last != (wcnt_q == n_m1)) len_err_d = 1'b1;
          if (wcnt_q == n_m1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        ram_waddr_d   = rcnt_q;
        ram_din_vld_d = 1'b1;
        rcnt_d        = rcnt_q + 1'b1;
        if (rcnt_q == n_m1) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (ocnt_q == n_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // returned pairs are only meaningful once the read sweep has begun
    if ((state_q == S_DRAIN || state_q == S_FLUSH) && ram_dout_vld) begin
      dout_d     = ram_rdata_itl;
      dout_vld_d = 1'b1;
      ocnt_d     = ocnt_q + 1'b1;
      if (ocnt_q == n_m1) begin
        dout_last_d = 1'b1;
        done_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      n_q             <= '0;
      wcnt_q          <= '0;
      rcnt_q          <= '0;
      ocnt_q          <= '0;
      len_err_q       <= 1'b0;
      dout_q          <= '0;
      dout_vld_q      <= 1'b0;
      dout_last_q     <= 1'b0;
      done_q          <= 1'b0;
      ram_wdata_q     <= '0;
      ram_waddr_q     <= '0;
      ram_wen_q       <= 1'b0;
      ram_pb_offset_q <= '0;
      ram_din_vld_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      wcnt_q          <= wcnt_d;
      rcnt_q          <= rcnt_d;
      ocnt_q          <= ocnt_d;
      len_err_q       <= len_err_d;
      dout_q          <= dout_d;
      dout_vld_q      <= dout_vld_d;
      dout_last_q     <= dout_last_d;
      done_q          <= done_d;
      ram_wdata_q     <= ram_wdata_d;
      ram_waddr_q     <= ram_waddr_d;
      ram_wen_q       <= ram_wen_d;
      ram_pb_offset_q <= ram_pb_offset_d;
      ram_din_vld_q   <= ram_din_vld_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign din_rdy       = (state_q == S_FILL);
  assign len_err       = len_err_q;
  assign dout          = dout_q;
  assign dout_vld      = dout_vld_q;
  assign dout_last     = dout_last_q;
  assign done          = done_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_waddr     = ram_waddr_q;
  assign ram_wen       = ram_wen_q;
  assign ram_pb_offset = ram_pb_offset_q;
  assign ram_din_vld   = ram_din_vld_q;

endmodule

// File: doc/hpgp_itl_ctrl.md
# hpgp_itl_ctrl

Sequencer for the HPGP turbo-interleaver RAM/ROM datapath (`ram_dual`). It accepts one PHY block (PB136 or PB520) as a stream of 2-bit pairs and writes it linearly into the interleaver RAM. It then sweeps the read address so the datapath returns the interleaved pairs, and forwards them downstream with framing (`dout_last`, `done`). It sits between the turbo-encoder pair stream and the interleaver memory and owns every RAM control signal.

## Interface
- `D_WIDTH`, 2, pair width; must match datapath.
- `A_WIDTH`, 12, RAM/ROM address width.
- `PB136_LEN`, 544, pairs per PB136 block.
- `PB520_LEN`, 2080, pairs per PB520 block.
- `PB136_OFS`, 0, ROM base for the PB136 permutation.
- `PB520_OFS`, 544, ROM base for the PB520 permutation.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  block start pulse; honoured only in IDLE.
- `pb_sel`  in  1  0 = PB136, 1 = PB520; sampled with an accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `din`  in  D_WIDTH  input pair.
- `din_vld`  in  1  input valid.
- `din_rdy`  out  1  input ready.
- `din_last`  in  1  marks the final pair of the block.
- `dout`  out  D_WIDTH  interleaved pair.
- `dout_vld`  out  1  output valid; there is no backpressure.
- `dout_last`  out  1  marks the Nth output pair.
- `done`  out  1  one-cycle pulse at block completion.
- `len_err`  out  1  sticky `din_last` framing error; cleared by an accepted `start`.
- `ram_wdata`  out  D_WIDTH  to datapath `wdata`.
- `ram_waddr`  out  A_WIDTH  to datapath `waddr`; carries the write address or the read sweep address.
- `ram_wen`  out  1  to datapath `wen`.
- `ram_pb_offset`  out  A_WIDTH  to datapath `pb_offset`.
- `ram_din_vld`  out  1  to datapath `din_vld`.
- `ram_rdata_itl`  in  D_WIDTH  from datapath `rdata_itl`.
- `ram_dout_vld`  in  1  from datapath `dout_vld`.

## Operation
- N = PB136_LEN or PB520_LEN, latched at `start` together with `ram_pb_offset`. Both stay held until the next accepted `start`.
- Counters are A_WIDTH-bit unsigned.
- Every `ram_*` output is registered.
- States:
  - IDLE: `start` -> FILL. The latch clears `wcnt`, `rcnt`, `ocnt` and `len_err`.
  - FILL: `din_rdy` = 1. A handshake (`din_vld & din_rdy`) at count `wcnt` registers `ram_wen` = 1, `ram_waddr` = `wcnt`, `ram_wdata` = `din`; then `wcnt`++. A handshake with `wcnt` == N-1 -> DRAIN.
  - DRAIN: `din_rdy` = 0. Each cycle registers `ram_waddr` = `rcnt`, `ram_din_vld` = 1, `ram_wen` = 0; then `rcnt`++. At `rcnt` == N-1 -> FLUSH.
  - FLUSH: waits until `ocnt` reaches N -> IDLE.
- Output path:
  - In DRAIN or FLUSH, `ram_dout_vld` registers `dout` = `ram_rdata_itl` and `dout_vld` = 1; `ocnt`++.
  - `dout_last` and `done` assert on the output where `ocnt` == N-1.
  - `ram_dout_vld` seen in IDLE or FILL is ignored.
- The pair bit-swap is done by the datapath. The controller passes pairs unmodified.
- `len_err` sets when either:
  - `din_last` = 1 on a handshake with `wcnt` != N-1, or
  - `din_last` = 0 on the handshake with `wcnt` == N-1.
- `len_err` does not alter sequencing: exactly N pairs are always consumed.
- A `start` outside IDLE is ignored, including a `start` in the `done` cycle.
- When `ram_wen` = 0 and `ram_din_vld` = 0, `ram_waddr` holds its last value.

## Timing
- Reset (synchronous, `rst` = 1 at an edge) forces state IDLE and clears all counters. These outputs go to 0: `busy`, `din_rdy`, `dout`, `dout_vld`, `dout_last`, `done`, `len_err`, `ram_wen`, `ram_din_vld`, `ram_waddr`, `ram_wdata`, `ram_pb_offset`.
- Reset mid-operation abandons the block. RAM contents are not cleared.
- `start` accepted at cycle s: `busy` = 1 and `din_rdy` = 1 from s+1.
- A handshake at cycle h gives `ram_wen` at h+1.
- Last input handshake at cycle t:
  - `din_rdy` = 0 from t+1.
  - `ram_din_vld` high for cycles t+2 .. t+N+1, with addresses 0..N-1.
  - The last write (t+1) precedes the first read.
- Datapath latency is fixed at 2 cycles, so `ram_dout_vld` is high for t+4 .. t+N+3.
- `dout_vld` is high for t+5 .. t+N+4, contiguous, one cycle after `ram_dout_vld`.
- `dout_last`, `done`: t+N+4. `busy` = 0 and `start` is accepted from t+N+5.
- Input gaps (`din_vld` = 0) stall FILL indefinitely. Gaps cannot occur on the output side.

## Test plan
- PB136 (`pb_sel` = 0), 544 pairs with `din` = k mod 4, contiguous:
  - `dout_vld` is high for exactly 544 contiguous cycles starting at t+5.
  - The sequence matches the golden model of the permutation ROM at offset 0 with the datapath swap.
  - `done` = 1 only at t+548.
- PB520 (`pb_sel` = 1), random `din_vld` gaps at 30% density:
  - 2080 writes occur with `ram_waddr` 0..2079 in order.
  - `ram_pb_offset` = 544 throughout.
  - 2080 outputs match the model.
- Framing errors:
  - `din_last` on pair 100 of PB136 -> `len_err` = 1 from the next cycle; the block still consumes 544 pairs and emits 544.
  - The next `start` clears `len_err`.
- Start handling:
  - `start` pulsed during FILL, DRAIN, and in the `done` cycle -> ignored; `ram_pb_offset` is unchanged.
  - Back-to-back blocks PB136 then PB520 with `start` at t+N+5 -> both correct.
- `rst` asserted for 1 cycle mid-DRAIN:
  - All outputs are 0 at the next cycle.
  - No `dout_vld` appears afterwards.
  - A fresh PB136 block then completes correctly.
- Reset values: hold `rst` for 3 cycles with `start` = 1 -> `busy` = 0, `din_rdy` = 0, and no state change.
